// File: rtl/leddc_pwm_scan_if.sv
// ---------------------------------------------------------------------------
// leddc_pwm_scan_if
// Serial line-load link between the host and the LED scan driver.
//
// Signals:
//   DAI       serial gray-level data. Channel 0 is sent first, and each
//             channel is sent LSB first.
//   DEN       DAI is valid this cycle.
//   line_req  the driver's pending line bank is empty and can take a line.
//
// Modports:
//   master  host side: drives DAI/DEN, observes line_req
//   slave   driver side: receives DAI/DEN, drives line_req
// ---------------------------------------------------------------------------
interface leddc_pwm_scan_if;
  logic DAI;
  logic DEN;
  logic line_req;

  modport master (
    output DAI,
    output DEN,
    input  line_req
  );

  modport slave (
    input  DAI,
    input  DEN,
    output line_req
  );
endinterface

// File: rtl/leddc_pwm_scan.sv
// ---------------------------------------------------------------------------
// leddc_pwm_scan
// Single-clock LED display driver. A serial stream carrying one scan line of
// CH gray levels (GW bits each) is collected into a pending bank. The PWM
// engine moves the pending bank into an active bank and drives CH
// pulse-width outputs for the current scan row. The row advances after
// every displayed line.
//
// Parameters:
//   CH    number of PWM channels (>= 2)
//   GW    gray-level bits per channel (2..12)
//   ROWS  scan rows per frame (>= 2). The row output width is
//         RW = max(1, clog2(ROWS)).
//
// Ports:
//   GCK       clock; all logic runs on the rising edge
//   rst_n     asynchronous active-low reset
//   link      serial line-load link (slave side: DAI, DEN, line_req)
//   Vsync     display enable; when low, the outputs are blanked
//   mode      0: full GW-bit PWM (period 2^GW-1)
//             1: fast (GW-1)-bit PWM (period 2^(GW-1))
//   OUT       registered PWM outputs, one per channel
//   row       current scan row
//   ovf       sticky overrun flag; only reset clears it
//
// Optional feature:
//   LEDDC_DITHER_EN  When defined, fast mode adds the gray LSB to the
//                    threshold on alternate frames. This recovers the LSB
//                    that the halved PWM resolution would otherwise drop.
// ---------------------------------------------------------------------------
module leddc_pwm_scan #(
  parameter  int CH   = 16,
  parameter  int GW   = 8,
  parameter  int ROWS = 16,
  localparam int RW   = (ROWS > 2) ? $clog2(ROWS) : 1
) (
  input  logic              GCK,
  input  logic              rst_n,
  leddc_pwm_scan_if.slave   link,
  input  logic              Vsync,
  input  logic              mode,
  output logic [CH-1:0]     OUT,
  output logic [RW-1:0]     row,
  output logic              ovf
);

  localparam int NB  = CH * GW;
  localparam int BCW = $clog2(NB);

  // Final counter value of a line in each PWM mode.
  localparam logic [GW-1:0] P0_LAST = GW'((2 ** GW) - 2);
  localparam logic [GW-1:0] P1_LAST = GW'((2 ** (GW - 1)) - 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(NB - 1);
  localparam logic [RW-1:0]  ROW_LAST = RW'(ROWS - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN
  } state_t;

  state_t state_q, state_d;

  // Input path storage. The shift register holds one bit less than a full
  // line. The completing bit goes straight into the pending bank together
  // with the shifted bits, so every stored bit gets read.
  logic [NB-2:0]  shift_q;
  logic [NB-1:0]  shift_next;
  logic [BCW-1:0] bit_cnt;
  logic [NB-1:0]  pend_q;
  logic           pend_v;
  logic           line_done;

  // Display-side storage.
  logic [NB-1:0]  act_q;
  logic           act_v;
  logic [GW-1:0]  cnt_q;
  logic           m_l;
  logic [CH-1:0]  on_vec;
  logic           line_last;

  // FSM-to-datapath controls.
  logic           do_load;
  logic           run_en;
  logic           restart;

`ifdef LEDDC_DITHER_EN
  logic           phase;
`endif

  // New bits enter at the top and move down. After NB bits, the first bit
  // received (channel 0, LSB) sits at bit 0 of the line.
  assign shift_next = {link.DAI, shift_q};
  assign line_done  = link.DEN && (bit_cnt == BIT_LAST);

  assign link.line_req = ~pend_v;

  // Serial capture and pending bank.
  // A line can complete in the same cycle as a LOAD. In that case, the new
  // line replaces the pending bank that LOAD is just taking away, so pend_v
  // stays set and no overrun is raised. A completion at any other time,
  // while pend_v is still set, overwrites the unused line and sets the
  // sticky overrun flag.
  always_ff @(posedge GCK or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      bit_cnt <= '0;
      pend_q  <= '0;
      pend_v  <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      if (link.DEN) begin
        shift_q <= shift_next[NB-1:1];
        if (line_done) begin
          bit_cnt <= '0;
          pend_q  <= shift_next;
        end else begin
          bit_cnt <= bit_cnt + BCW'(1);
        end
      end

      if (line_done) begin
        pend_v <= 1'b1;
      end else if (do_load) begin
        pend_v <= 1'b0;
      end

      if (line_done && pend_v && !do_load) begin
        ovf <= 1'b1;
      end
    end
  end

  // State register of the PWM sequencer.
  always_ff @(posedge GCK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and datapath controls.
  // Vsync low overrides everything and parks the sequencer in IDLE. The
  // active bank, row and frame phase stay untouched, so display resumes on
  // the same line. At the end of each displayed line, a waiting pending
  // line wins. Otherwise the active line repeats and mode is sampled again.
  always_comb begin
    state_d   = state_q;
    do_load   = 1'b0;
    run_en    = 1'b0;
    restart   = 1'b0;
    line_last = m_l ? (cnt_q == P1_LAST) : (cnt_q == P0_LAST);

    if (!Vsync) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (pend_v) begin
            state_d = LOAD;
          end else if (act_v) begin
            state_d = RUN;
            restart = 1'b1;
          end
        end
        LOAD: begin
          do_load = 1'b1;
          state_d = RUN;
        end
        RUN: begin
          run_en = 1'b1;
          if (line_last) begin
            if (pend_v) begin
              state_d = LOAD;
            end else begin
              restart = 1'b1;
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Per-channel threshold compare. In full mode, the threshold is the gray
  // value itself, over a period of 2^GW-1 counts. This makes the largest
  // gray value a steady on. In fast mode, the gray value is halved to fit a
  // 2^(GW-1) period. The optional dither adds the dropped LSB back on odd
  // frames.
  always_comb begin
    logic [GW-1:0] g;
    logic [GW-1:0] thr;
    g      = '0;
    thr    = '0;
    on_vec = '0;
    for (int i = 0; i < CH; i++) begin
      g = act_q[i*GW +: GW];
      if (m_l) begin
`ifdef LEDDC_DITHER_EN
        thr = (g >> 1) + GW'(g[0] & phase);
`else
        thr = g >> 1;
`endif
      end else begin
        thr = g;
      end
      on_vec[i] = (cnt_q < thr);
    end
  end

  // PWM datapath: active bank, counter, latched mode, outputs and row.
  // OUT is blanked in every cycle that is not a RUN cycle. The row advances
  // at the same edge that writes the last output of the line.
  always_ff @(posedge GCK or negedge rst_n) begin
    if (!rst_n) begin
      act_q <= '0;
      act_v <= 1'b0;
      cnt_q <= '0;
      m_l   <= 1'b0;
      OUT   <= '0;
      row   <= '0;
    end else begin
      if (!Vsync) begin
        OUT   <= '0;
        cnt_q <= '0;
      end else if (do_load) begin
        act_q <= pend_q;
        act_v <= 1'b1;
        cnt_q <= '0;
        m_l   <= mode;
        OUT   <= '0;
      end else if (run_en) begin
        OUT <= on_vec;
        if (line_last) begin
          cnt_q <= '0;
          row   <= (row == ROW_LAST) ? '0 : row + RW'(1);
          if (restart) begin
            m_l <= mode;
          end
        end else begin
          cnt_q <= cnt_q + GW'(1);
        end
      end else if (restart) begin
        cnt_q <= '0;
        m_l   <= mode;
        OUT   <= '0;
      end else begin
        OUT <= '0;
      end
    end
  end

`ifdef LEDDC_DITHER_EN
  // The frame phase flips each time the row wraps from the last row back
  // to row 0. Dither therefore alternates once per full frame.
  always_ff @(posedge GCK or negedge rst_n) begin
    if (!rst_n) begin
      phase <= 1'b0;
    end else if (Vsync && run_en && line_last && (row == ROW_LAST)) begin
      phase <= ~phase;
    end
  end
`endif

endmodule

// File: tb/tb_leddc_pwm_scan.sv
// ---------------------------------------------------------------------------
// tb_leddc_pwm_scan
// Self-checking bench for leddc_pwm_scan with CH=16, GW=8, ROWS=16.
// Inputs are driven, and outputs sampled, on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_leddc_pwm_scan;

  localparam int CH   = 16;
  localparam int GW   = 8;
  localparam int ROWS = 16;
  localparam int RW   = 4;
  localparam int NB   = CH * GW;

  logic          GCK = 1'b0;
  logic          rst_n;
  logic          Vsync;
  logic          mode;
  logic [CH-1:0] OUT;
  logic [RW-1:0] row;
  logic          ovf;

  int total = 0;
  int bad   = 0;
  int hi_cnt [CH];

  typedef struct {
    string         name;
    logic [NB-1:0] line;
    logic          md;
    int            e0;
    int            e1;
    int            e2;
    int            e3;
  } vec_t;

  vec_t vecs [4];

  leddc_pwm_scan_if link();

  leddc_pwm_scan #(
    .CH   (CH),
    .GW   (GW),
    .ROWS (ROWS)
  ) dut (
    .GCK   (GCK),
    .rst_n (rst_n),
    .link  (link),
    .Vsync (Vsync),
    .mode  (mode),
    .OUT   (OUT),
    .row   (row),
    .ovf   (ovf)
  );

  always #5 GCK = ~GCK;

  // Compares one observed value against its hand-computed expectation.
  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge GCK);
  endtask

  // Builds a line: ch0, ch1 and ch2 get their own values; all other
  // channels get gr.
  function automatic logic [NB-1:0] mkLine(input logic [7:0] g0, input logic [7:0] g1,
                                            input logic [7:0] g2, input logic [7:0] gr);
    logic [NB-1:0] l;
    for (int i = 0; i < CH; i++) l[i*GW +: GW] = gr;
    l[7:0]   = g0;
    l[15:8]  = g1;
    l[23:16] = g2;
    return l;
  endfunction

  // Sends bits lo..hi-1 of a line on consecutive cycles, then idles DEN.
  task automatic sendBits(input logic [NB-1:0] l, input int lo, input int hi);
    for (int b = lo; b < hi; b++) begin
      @(negedge GCK);
      link.DEN = 1'b1;
      link.DAI = l[b];
    end
    @(negedge GCK);
    link.DEN = 1'b0;
    link.DAI = 1'b0;
  endtask

  task automatic doReset();
    @(negedge GCK);
    rst_n    = 1'b0;
    Vsync    = 1'b0;
    mode     = 1'b0;
    link.DEN = 1'b0;
    link.DAI = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(1);
  endtask

  // Counts the high samples of each channel over p consecutive cycles.
  task automatic countHighs(input int p);
    for (int c = 0; c < CH; c++) hi_cnt[c] = 0;
    repeat (p) begin
      @(negedge GCK);
      for (int c = 0; c < CH; c++) if (OUT[c]) hi_cnt[c]++;
    end
  endtask

  // Loads one line with Vsync low, enables the display, and measures one
  // full PWM period.
  task automatic applyStimulus(input vec_t v);
    doReset();
    mode = v.md;
    sendBits(v.line, 0, NB);
    Vsync = 1'b1;
    tick(3);
    countHighs(v.md ? 128 : 255);
  endtask

  initial begin
    logic [NB-1:0] la;
    logic [NB-1:0] lb;
    int guard;
    int exp_f1;

    vecs[0] = '{"m0_a", mkLine(8'h00, 8'hFF, 8'h80, 8'h01), 1'b0, 0,   255, 128, 1};
    vecs[1] = '{"m0_b", mkLine(8'h7F, 8'hFE, 8'h02, 8'h40), 1'b0, 127, 254, 2,   64};
    vecs[2] = '{"m1_a", mkLine(8'h00, 8'hFF, 8'h80, 8'h03), 1'b1, 0,   127, 64,  1};
    vecs[3] = '{"m1_b", mkLine(8'h10, 8'hFE, 8'h01, 8'h21), 1'b1, 8,   127, 0,   16};

    rst_n    = 1'b0;
    Vsync    = 1'b0;
    mode     = 1'b0;
    link.DEN = 1'b0;
    link.DAI = 1'b0;

    // Reset values, then a long idle period.
    tick(2);
    checkOutput("rst_out", OUT, 0);
    checkOutput("rst_row", row, 0);
    checkOutput("rst_line_req", link.line_req, 1);
    checkOutput("rst_ovf", ovf, 0);
    rst_n = 1'b1;
    tick(1000);
    checkOutput("idle_out", OUT, 0);
    checkOutput("idle_row", row, 0);
    checkOutput("idle_line_req", link.line_req, 1);
    checkOutput("idle_ovf", ovf, 0);

    // line_req timing, LOAD latency and row-advance timing in mode 0.
    la = mkLine(8'h00, 8'hFF, 8'h80, 8'h01);
    sendBits(la, 0, NB - 1);
    checkOutput("line_req_before_last", link.line_req, 1);
    sendBits(la, NB - 1, NB);
    checkOutput("line_req_after_last", link.line_req, 0);
    Vsync = 1'b1;
    tick(1);
    checkOutput("load_lat_1", OUT[1], 0);
    tick(1);
    checkOutput("load_lat_2", OUT[1], 0);
    checkOutput("line_req_after_load", link.line_req, 1);
    tick(1);
    checkOutput("load_lat_3", OUT[1], 1);
    tick(253);
    checkOutput("row_before_wrap", row, 0);
    tick(1);
    checkOutput("row_after_line", row, 1);

    // Table of single-line PWM vectors.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(vecs[i]);
      checkOutput({vecs[i].name, "_ch0"}, hi_cnt[0], vecs[i].e0);
      checkOutput({vecs[i].name, "_ch1"}, hi_cnt[1], vecs[i].e1);
      checkOutput({vecs[i].name, "_ch2"}, hi_cnt[2], vecs[i].e2);
      checkOutput({vecs[i].name, "_ch3"}, hi_cnt[3], vecs[i].e3);
    end

    // Fast mode, g=3 on all channels: frame 0, then frame 1.
`ifdef LEDDC_DITHER_EN
    exp_f1 = 2;
`else
    exp_f1 = 1;
`endif
    doReset();
    mode = 1'b1;
    sendBits(mkLine(8'h03, 8'h03, 8'h03, 8'h03), 0, NB);
    Vsync = 1'b1;
    tick(3);
    countHighs(128);
    checkOutput("dither_frame0", hi_cnt[0], 1);
    guard = 0;
    while (row != 4'd15 && guard < 5000) begin tick(1); guard++; end
    while (row != 4'd0 && guard < 5000) begin tick(1); guard++; end
    checkOutput("dither_wrap_seen", guard < 5000, 1);
    countHighs(128);
    checkOutput("dither_frame1", hi_cnt[0], exp_f1);
    checkOutput("dither_frame1_ch9", hi_cnt[9], exp_f1);

    // Overrun: two lines while blanked; the second line is displayed.
    doReset();
    la = mkLine(8'h00, 8'hFF, 8'h00, 8'h00);
    lb = mkLine(8'h00, 8'h00, 8'hFF, 8'h00);
    sendBits(la, 0, NB);
    checkOutput("ovf_after_first", ovf, 0);
    sendBits(lb, 0, NB);
    checkOutput("ovf_after_second", ovf, 1);
    Vsync = 1'b1;
    tick(3);
    countHighs(255);
    checkOutput("ovf_line_ch1", hi_cnt[1], 0);
    checkOutput("ovf_line_ch2", hi_cnt[2], 255);
    checkOutput("ovf_sticky", ovf, 1);
    checkOutput("ovf_row_moved", row, 1);
    checkOutput("pre_reset_out2", OUT[2], 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_out", OUT, 0);
    checkOutput("async_rst_row", row, 0);
    checkOutput("async_rst_line_req", link.line_req, 1);
    checkOutput("async_rst_ovf", ovf, 0);
    @(negedge GCK);
    Vsync = 1'b0;
    rst_n = 1'b1;

    // Vsync drop at cnt=50, then resume without a LOAD.
    doReset();
    sendBits(mkLine(8'h00, 8'hFF, 8'h80, 8'h01), 0, NB);
    Vsync = 1'b1;
    tick(52);
    checkOutput("vs_out1_running", OUT[1], 1);
    Vsync = 1'b0;
    tick(1);
    checkOutput("vs_blank_out", OUT, 0);
    checkOutput("vs_blank_row", row, 0);
    tick(3);
    Vsync = 1'b1;
    tick(1);
    checkOutput("vs_resume_1", OUT[3], 0);
    tick(1);
    checkOutput("vs_resume_2", OUT[3], 1);
    tick(1);
    checkOutput("vs_resume_3", OUT[3], 0);
    tick(252);
    checkOutput("vs_row_hold", row, 0);
    tick(1);
    checkOutput("vs_row_next", row, 1);

    // Completion coinciding with LOAD.
    doReset();
    la = mkLine(8'h00, 8'hFF, 8'h80, 8'h01);
    lb = mkLine(8'h00, 8'h00, 8'hFF, 8'h00);
    sendBits(la, 0, NB);
    sendBits(lb, 0, NB - 1);
    Vsync = 1'b1;
    sendBits(lb, NB - 1, NB);
    checkOutput("coin_line_req", link.line_req, 0);
    checkOutput("coin_ovf", ovf, 0);
    tick(1);
    checkOutput("coin_first_line", OUT[1], 1);
    tick(254);
    checkOutput("coin_pend_held", link.line_req, 0);
    tick(1);
    checkOutput("coin_second_load", link.line_req, 1);
    tick(2);
    checkOutput("coin_second_ch1", OUT[1], 0);
    checkOutput("coin_second_ch2", OUT[2], 1);
    checkOutput("coin_ovf_end", ovf, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/leddc_pwm_scan.md
# leddc_pwm_scan

Parametrised single-clock LED display driver. It receives serial gray-level data for one scan line of `CH` channels, holds it in a ping-pong line buffer, and drives `CH` PWM outputs for the current row. Scan rows advance automatically. The driver sits between the host serial link and the LED column drivers. It is the successor of the 16-channel dual-clock driver and adds parametric width, channel count and row count, an overrun flag and an optional temporal dither.

## Interface
- `CH`, 16, number of PWM channels (≥2)
- `GW`, 8, gray-level bits per channel (2..12)
- `ROWS`, 16, scan rows per frame (≥2); `RW = max(1, clog2(ROWS))`
- `GCK`  in  1  single clock; all logic on posedge
- `rst_n`  in  1  asynchronous, active-low reset
- `DAI`  in  1  serial data; channel 0 first, LSB first within channel
- `DEN`  in  1  DAI valid this cycle
- `Vsync`  in  1  display enable; low blanks outputs
- `mode`  in  1  0: full `GW`-bit PWM; 1: fast `(GW-1)`-bit PWM
- `OUT`  out  CH  PWM outputs, registered
- `row`  out  RW  current scan row
- `line_req`  out  1  high when the pending bank is empty
- `ovf`  out  1  sticky overrun flag; cleared only by reset

## Operation
- **Input path:**
  - Shift register of `CH*GW` bits plus bit counter; each `DEN=1` cycle shifts in `DAI`.
  - On the `CH*GW`-th bit: copy to the pending bank, set `pend_v`, clear the counter.
  - Completion while `pend_v=1`: set `ovf`; pending is overwritten.
  - `DEN=0` holds shift register and counter.
- **`line_req`** = `~pend_v`.
- **PWM FSM states:** IDLE, LOAD, RUN.
  - IDLE: `OUT=0`. If `Vsync`: go to LOAD when `pend_v`, else RUN when `act_v`, else stay.
  - LOAD (1 cycle): active bank ← pending; `act_v←1`; `pend_v←0`; `cnt←0`; latch `mode` into `m_l`; `OUT=0`.
    - If completion coincides with LOAD, the new line is written to pending and `pend_v` stays 1. No `ovf` is raised.
  - RUN: `OUT[i] ← (cnt < thr_i)`; `cnt` increments.
    - At `cnt==P-1`: `row ← (row==ROWS-1) ? 0 : row+1`. On that wrap, `phase` toggles.
    - Next state: LOAD if `pend_v`, else RUN with `cnt←0` and `m_l←mode`, repeating the active line.
  - `Vsync` low in any state: go to IDLE next cycle; `OUT←0`; `cnt←0`. `row`, `phase`, banks and `act_v` are kept.
- **Thresholds** (`g` = channel gray value):
  - `m_l=0`: `P = 2^GW - 1`; `thr = g`. So `g=0` is never on, and `g=2^GW-1` is always on.
  - `m_l=1`: `P = 2^(GW-1)`; `thr = (g>>1) + (g[0] & phase)` when dither is compiled in.
  - Compare width: `GW` bits, unsigned.

## Timing
- Reset values: `OUT=0`, `row=0`, `line_req=1`, `ovf=0`. Internally `pend_v=0`, `act_v=0`, `phase=0`, state IDLE, counters 0.
- Last serial bit at edge k: `line_req` falls at edge k+1.
- From IDLE with `Vsync=1` and `pend_v`: LOAD at edge n+1, first `OUT` update at edge n+2.
- Each line takes P cycles in RUN, plus 1 cycle if preceded by LOAD.
- `row` changes at the same edge as the last `OUT` update of the line.
- `ovf` rises the cycle after the offending completion.
- Asynchronous reset mid-RUN or mid-shift: all outputs reach their reset values immediately, and the partial line is discarded.

## Configuration
- `LEDDC_DITHER_EN` defined: in `m_l=1`, the odd-LSB threshold adds `phase`, which alternates every frame (`ROWS` lines).
- Not defined: `thr = g>>1` in `m_l=1`; `phase` logic is removed and `g[0]` is ignored.

## Test plan
All scenarios use `CH=16`, `GW=8`, `ROWS=16`.
- Reset: `rst_n=0` → `OUT=0`, `row=0`, `line_req=1`, `ovf=0`. Release with idle inputs → unchanged for 1000 cycles.
- Mode 0 line: ch0=0x00, ch1=0xFF, ch2=0x80, ch3..15=0x01, `Vsync=1`:
  - `OUT[0]` never high; `OUT[1]` high 255 cycles; `OUT[2]` high 128; `OUT[3]` high 1.
  - `row` 0→1 at 256 cycles after LOAD.
- Mode 1, g=0x03 on all channels:
  - With `LEDDC_DITHER_EN`: high 1 of 128 cycles for frame 0, 2 of 128 for frame 1 (after 16 lines).
  - Without the macro: high 1 cycle every frame.
- Overrun: two lines shifted with `Vsync=0` → `ovf=1`. Raise `Vsync` → the second line is displayed; `ovf` stays 1 until reset.
- `Vsync` dropped at cnt=50 → `OUT=0` the next cycle, `row` unchanged. Re-raise → the same line restarts from cnt=0 (no LOAD).
- Coincident completion and LOAD → `pend_v` stays 1, `ovf=0`. Assert `rst_n=0` mid-RUN → `OUT=0` immediately.
